// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM state enum,
// ALU control encodings, opcode values, ALUOp codes, datapath mux selects and
// the immediate-format selector.
// Ports: none (package).
// Optional feature macro used by the importers: ALU_EXT_OPS_EN.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StFault
  } state_e;

  // ALU control encodings (4-bit core, zero-extended to ALUCTRL_W at the top).
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSll  = 4'd6;
  localparam logic [3:0] AluSrl  = 4'd7;
  localparam logic [3:0] AluSra  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OpStore:  imm_sel = ImmS;
      OpBranch: imm_sel = ImmB;
      OpJal:    imm_sel = ImmJ;
      default:  imm_sel = ImmI;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct3/funct7b5 to an ALU control
// code and flags funct3 values the build does not support.
// Ports:
//   alu_op    in  2  00 add, 01 sub, 10 decode funct fields
//   funct3    in  3  instr[14:12]
//   funct7b5  in  1  instr[30]
//   is_rtype  in  1  opcode is R-type (selects SUB for funct3=000)
//   alu_code  out 4  ALU control encoding
//   illegal   out 1  funct3 unsupported in this build
// Macro ALU_EXT_OPS_EN: adds XOR, SLTU, SLL, SRL/SRA; otherwise those are illegal.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [3:0] alu_code,
  output logic       illegal
);

  always_comb begin
    alu_code = AluAdd;
    illegal  = 1'b0;
    case (alu_op)
      AluOpSub: alu_code = AluSub;
      AluOpFunct: begin
        case (funct3)
          // addi ignores funct7b5; only R-type uses it to select SUB.
          3'b000: alu_code = (is_rtype && funct7b5) ? AluSub : AluAdd;
          3'b010: alu_code = AluSlt;
          3'b110: alu_code = AluOr;
          3'b111: alu_code = AluAnd;
`ifdef ALU_EXT_OPS_EN
          3'b100: alu_code = AluXor;
          3'b011: alu_code = AluSltu;
          3'b001: alu_code = AluSll;
          3'b101: alu_code = funct7b5 ? AluSra : AluSrl;
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: alu_code = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Control FSM for the multi-cycle RV32I core. Sequences fetch, decode, execute,
// memory and writeback, drives every datapath mux/enable, and traps on illegal
// instructions or memory-wait timeouts into a FAULT state held until reset.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   op, funct3, funct7b5       instruction fields from IR
//   zero                       ALU zero flag (branch decision)
//   mem_ready                  memory completes the current request
//   mem_req, mem_write, adr_src        memory interface controls
//   ir_write, pc_write, reg_write      datapath strobes (forced 0 in reset)
//   result_src, alu_src_a, alu_src_b   datapath mux selects
//   imm_src                    immediate format, combinational from op
//   alu_control                ALU operation
//   illegal_instr, bus_err     sticky fault flags
// Macro ALU_EXT_OPS_EN: enables XOR/SLTU/SLL/SRL/SRA in the ALU decoder.
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal_instr,
  output logic                 bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic            illegal_q;
  logic            bus_err_q;

  logic       mem_state;
  logic       mem_wait;
  logic       timeout;
  logic [1:0] alu_op;
  logic [3:0] alu_code;
  logic       funct_illegal;
  logic       mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign mem_wait  = mem_state && !mem_ready;
  // The TIMEOUT_CYCLES-th consecutive stall cycle faults; mem_ready that cycle still wins.
  assign timeout   = mem_wait && (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  alu_op_decoder u_alu_op_decoder (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .is_rtype (op == OpRtype),
    .alu_code (alu_code),
    .illegal  (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= (mem_wait && !timeout) ? wait_cnt_q + CntW'(1) : '0;
      if (timeout) begin
        state_q   <= StFault;
        bus_err_q <= 1'b1;
      end else begin
        case (state_q)
          StFetch: if (mem_ready) state_q <= StDecode;
          StDecode: begin
            case (op)
              OpLoad, OpStore: state_q <= StMemAdr;
              OpRtype:         state_q <= StExecR;
              OpItype:         state_q <= StExecI;
              OpBranch:        state_q <= StBeq;
              OpJal:           state_q <= StJal;
              default: begin
                state_q   <= StFault;
                illegal_q <= 1'b1;
              end
            endcase
          end
          StMemAdr:   state_q <= (op == OpStore) ? StMemWrite : StMemRead;
          StMemRead:  if (mem_ready) state_q <= StMemWb;
          StMemWrite: if (mem_ready) state_q <= StFetch;
          StMemWb, StAluWb, StBeq: state_q <= StFetch;
          StExecR, StExecI: begin
            if (funct_illegal) begin
              state_q   <= StFault;
              illegal_q <= 1'b1;
            end else begin
              state_q <= StAluWb;
            end
          end
          StJal:   state_q <= StAluWb;
          StFault: state_q <= StFault;
          default: state_q <= StFault;
        endcase
      end
    end
  end

  always_comb begin
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    result_src  = ResAluOut;
    alu_src_a   = SrcAPc;
    alu_src_b   = SrcBRs2;
    alu_op      = AluOpAdd;
    case (state_q)
      StFetch: begin
        mem_req_s  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
      end
      StMemWrite: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
      end
      StMemWb: begin
        result_src  = ResData;
        reg_write_s = 1'b1;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpFunct;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb: reg_write_s = 1'b1;
      StBeq: begin
        alu_src_a  = SrcARs1;
        alu_op     = AluOpSub;
        pc_write_s = zero;
      end
      StJal: begin
        alu_src_a  = SrcAOldPc;
        alu_src_b  = SrcBFour;
        pc_write_s = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req       = mem_req_s & rst_n;
  assign mem_write     = mem_write_s & rst_n;
  assign ir_write      = ir_write_s & rst_n;
  assign pc_write      = pc_write_s & rst_n;
  assign reg_write     = reg_write_s & rst_n;
  assign imm_src       = imm_sel(op);
  assign alu_control   = ALUCTRL_W'(alu_code);
  assign illegal_instr = illegal_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Self-checking bench for multicycle_ctrl_unit: a table of single-instruction
// vectors plus hand-written sequences for stalls, faults, timeout and reset.
module tb_multicycle_ctrl_unit;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_FAULT = 4'd11;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = OP_R;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_control;
  logic       illegal_instr, bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] sb [$];

  multicycle_ctrl_unit #(.ALUCTRL_W(4), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal_instr(illegal_instr), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic            z;
    logic [3:0]      alu;
    logic [1:0]      imm;
    logic [2:0]      n;
    logic [5:0][3:0] seq;
  } vec_t;

  // Expected outputs per state, written from the state table of the control unit.
  function automatic logic [17:0] exp_out(input logic [3:0] st, input logic rdy, input logic z,
                                          input logic [3:0] fn, input logic ill, input logic be,
                                          input logic rst);
    logic mreq, mwr, adr, irw, pcw, rw;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
    {mreq, mwr, adr, irw, pcw, rw} = '0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 4'd0;
    case (st)
      S_FETCH:    begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin mreq = 1; adr = 1; end
      S_MEMWRITE: begin mreq = 1; mwr = 1; adr = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_EXECR:    begin a = 2'b10; b = 2'b00; alu = fn; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; alu = fn; end
      S_ALUWB:    rw = 1;
      S_BEQ:      begin a = 2'b10; b = 2'b00; alu = 4'd1; pcw = z; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      default:    ;
    endcase
    if (rst) {mreq, mwr, irw, pcw, rw} = '0;
    return {mreq, mwr, adr, irw, pcw, rw, rs, a, b, alu, ill, be};
  endfunction

  function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input logic [3:0] alu, input logic [1:0] imm,
                              input logic [2:0] n, input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
    vec_t v;
    v = '0;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.alu = alu; v.imm = imm; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    return v;
  endfunction

  task automatic cycle(input string nm, input logic [3:0] st, input logic rdy,
                       input logic [3:0] fn, input logic ill, input logic be, input logic rst);
    logic [17:0] got, want;
    mem_ready = rdy;
    sb.push_back(exp_out(st, rdy, zero, fn, ill, be, rst));
    @(negedge clk);
    want = sb.pop_front();
    got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src, alu_src_a,
           alu_src_b, alu_control, illegal_instr, bus_err};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] prev, input logic ill, input logic be);
    rst_n = 1'b0;
    cycle("rst_entry", prev, 1'b1, 4'd0, ill, be, 1'b1);
    cycle("rst_hold", S_FETCH, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  vec_t vecs [11];

  initial begin
    vecs[0]  = mk(OP_R,   3'b000, 0, 0, 4'd0, 2'b00, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, 0);
    vecs[1]  = mk(OP_R,   3'b000, 1, 0, 4'd1, 2'b00, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, 0);
    vecs[2]  = mk(OP_I,   3'b000, 1, 0, 4'd0, 2'b00, 4, S_FETCH, S_DECODE, S_EXECI, S_ALUWB, 0);
    vecs[3]  = mk(OP_R,   3'b010, 0, 0, 4'd5, 2'b00, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, 0);
    vecs[4]  = mk(OP_I,   3'b110, 0, 0, 4'd3, 2'b00, 4, S_FETCH, S_DECODE, S_EXECI, S_ALUWB, 0);
    vecs[5]  = mk(OP_R,   3'b111, 0, 0, 4'd2, 2'b00, 4, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, 0);
    vecs[6]  = mk(OP_SW,  3'b010, 0, 0, 4'd0, 2'b01, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE,
                  0);
    vecs[7]  = mk(OP_LW,  3'b010, 0, 0, 4'd0, 2'b00, 5, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
                  S_MEMWB);
    vecs[8]  = mk(OP_BEQ, 3'b000, 0, 1, 4'd0, 2'b10, 3, S_FETCH, S_DECODE, S_BEQ, 0, 0);
    vecs[9]  = mk(OP_BEQ, 3'b000, 0, 0, 4'd0, 2'b10, 3, S_FETCH, S_DECODE, S_BEQ, 0, 0);
    vecs[10] = mk(OP_JAL, 3'b000, 0, 0, 4'd0, 2'b11, 4, S_FETCH, S_DECODE, S_JAL, S_ALUWB, 0);

    do_reset(S_FETCH, 1'b0, 1'b0);

    // Table: each instruction runs to completion with mem_ready=1.
    for (int i = 0; i < 11; i++) begin
      set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7);
      zero = vecs[i].z;
      #1;
      n_tests++;
      if (imm_src !== vecs[i].imm) begin
        n_fail++;
        $display("FAIL vec%0d.imm_src: got %b expected %b", i, imm_src, vecs[i].imm);
      end
      for (int c = 0; c < int'(vecs[i].n); c++)
        cycle($sformatf("vec%0d.c%0d", i, c), vecs[i].seq[c], 1'b1, vecs[i].alu, 0, 0, 0);
    end
    zero = 1'b0;

    // lw with three stall cycles in MEMREAD: 8 cycles, one reg_write.
    set_instr(OP_LW, 3'b010, 1'b0);
    cycle("lw.fetch", S_FETCH, 1, 0, 0, 0, 0);
    cycle("lw.decode", S_DECODE, 1, 0, 0, 0, 0);
    cycle("lw.memadr", S_MEMADR, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle($sformatf("lw.stall%0d", k), S_MEMREAD, 0, 0, 0, 0, 0);
    cycle("lw.memread", S_MEMREAD, 1, 0, 0, 0, 0);
    cycle("lw.memwb", S_MEMWB, 1, 0, 0, 0, 0);
    cycle("lw.next", S_FETCH, 1, 0, 0, 0, 0);

    // Unsupported opcode traps and stays in FAULT until reset.
    set_instr(7'b1111111, 3'b000, 1'b0);
    cycle("ill.decode", S_DECODE, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle($sformatf("ill.fault%0d", k), S_FAULT, 1, 0, 1, 0, 0);
    do_reset(S_FAULT, 1'b1, 1'b0);

    // xor is legal only with the extended ALU ops.
    set_instr(OP_R, 3'b100, 1'b0);
    cycle("xor.fetch", S_FETCH, 1, 0, 0, 0, 0);
    cycle("xor.decode", S_DECODE, 1, 0, 0, 0, 0);
`ifdef ALU_EXT_OPS_EN
    cycle("xor.exec", S_EXECR, 1, 4'd4, 0, 0, 0);
    cycle("xor.wb", S_ALUWB, 1, 0, 0, 0, 0);
`else
    cycle("xor.exec", S_EXECR, 1, 4'd0, 0, 0, 0);
    for (int k = 0; k < 2; k++) cycle($sformatf("xor.fault%0d", k), S_FAULT, 1, 0, 1, 0, 0);
    do_reset(S_FAULT, 1'b1, 1'b0);
`endif

    // Boundary: 254 stall cycles, mem_ready on the 255th wins over the timeout.
    set_instr(OP_R, 3'b000, 1'b0);
    for (int k = 0; k < 254; k++) cycle($sformatf("edge.stall%0d", k), S_FETCH, 0, 0, 0, 0, 0);
    cycle("edge.fetch", S_FETCH, 1, 0, 0, 0, 0);
    cycle("edge.decode", S_DECODE, 1, 0, 0, 0, 0);
    cycle("edge.exec", S_EXECR, 1, 0, 0, 0, 0);
    cycle("edge.wb", S_ALUWB, 1, 0, 0, 0, 0);

    // Timeout: 255 stall cycles in FETCH fault with bus_err; reset recovers.
    for (int k = 0; k < 255; k++) cycle($sformatf("to.stall%0d", k), S_FETCH, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) cycle($sformatf("to.fault%0d", k), S_FAULT, 1, 0, 0, 1, 0);
    do_reset(S_FAULT, 1'b0, 1'b1);
    cycle("rec.fetch", S_FETCH, 1, 0, 0, 0, 0);
    cycle("rec.decode", S_DECODE, 1, 0, 0, 0, 0);
    cycle("rec.exec", S_EXECR, 1, 0, 0, 0, 0);
    cycle("rec.wb", S_ALUWB, 1, 0, 0, 0, 0);
    cycle("rec.next", S_FETCH, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
